// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes and
// fixed PC constants.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_IM_MSB     = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] RESET_PC     = 32'h0000_3000;

  // EPC always holds a word address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational exception/interrupt request generation with interrupt priority.
module cp0_req_gen
  import cp0_pkg::*;
(
  input  logic       reset,
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hwint,
  input  logic [4:0] exc_code,
  output logic       req,
  output logic [4:0] rec_code
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req  = ie & ~exl & (|(hwint & im));
    exc_req  = (exc_code != EXC_INT) & ~exl;
    // Registers are already clear in reset, but exc_req is not; gate explicitly.
    req      = reset & (int_req | exc_req);
    rec_code = int_req ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC) with exception entry, eret and mtc0/mfc0.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] vpc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hwint,
  input  logic        eret,
  output logic        req,
  output logic [31:0] rdata,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [4:0]  rec_code;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  cp0_req_gen u_req_gen (
    .reset    (reset),
    .ie       (ie_q),
    .exl      (exl_q),
    .im       (im_q),
    .hwint    (hwint),
    .exc_code (exc_code),
    .req      (req),
    .rec_code (rec_code)
  );

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hwint;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bd;
      exc_d = rec_code;
      epc_d = word_align(bd ? vpc - 32'd4 : vpc);
    end else begin
      if (eret) begin
        exl_d = 1'b0;
      end
      // An explicit SR write in the eret cycle takes precedence over the eret clear.
      if (en) begin
        case (addr)
          REG_SR: begin
            im_d  = wdata[SR_IM_MSB:SR_IM_LSB];
            exl_d = wdata[SR_EXL_BIT];
            ie_d  = wdata[SR_IE_BIT];
          end
          REG_EPC: epc_d = word_align(wdata);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    sr_val                              = '0;
    sr_val[SR_IM_MSB:SR_IM_LSB]         = im_q;
    sr_val[SR_EXL_BIT]                  = exl_q;
    sr_val[SR_IE_BIT]                   = ie_q;
    cause_val                           = '0;
    cause_val[CAUSE_BD_BIT]             = bd_q;
    cause_val[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip_q;
    cause_val[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_q;
    case (addr)
      REG_SR:    rdata = sr_val;
      REG_CAUSE: rdata = cause_val;
      REG_EPC:   rdata = epc_q;
      default:   rdata = '0;
    endcase
    epc_out = epc_q;
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus queues expected outputs, a negedge
// monitor pops and compares them.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hwint;
  logic        eret;
  logic        req;
  logic [31:0] rdata;
  logic [31:0] epc_out;

  localparam int KReq = 0;
  localparam int KRd  = 1;
  localparam int KEpc = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  cp0_unit dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .addr     (addr),
    .wdata    (wdata),
    .vpc      (vpc),
    .bd       (bd),
    .exc_code (exc_code),
    .hwint    (hwint),
    .eret     (eret),
    .req      (req),
    .rdata    (rdata),
    .epc_out  (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        KReq:    act = {31'b0, req};
        KRd:     act = rdata;
        default: act = epc_out;
      endcase
      checks = checks + 1;
      if (act !== cur.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; addr = '0; wdata = '0; vpc = '0; bd = 1'b0;
    exc_code = '0; hwint = '0; eret = 1'b0;

    // In reset: everything reads 0, req held low even with an exception present.
    tick();
    addr = 5'd12; exc_code = 5'd8;
    push(KRd, 32'h0, "rst_sr"); push(KReq, 32'h0, "rst_req"); push(KEpc, 32'h0, "rst_epc");
    tick();
    addr = 5'd13; push(KRd, 32'h0, "rst_cause");
    tick();
    addr = 5'd14; exc_code = 5'd0; push(KRd, 32'h0, "rst_epc_rd");
    tick();
    reset = 1'b1;

    // Interrupt entry
    tick();
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; push(KReq, 32'h0, "idle_req");
    tick();
    en = 1'b0; hwint = 6'b000001; vpc = 32'h3010; bd = 1'b0;
    push(KRd, 32'h401, "sr_write"); push(KReq, 32'h1, "int_req");
    tick();
    addr = 5'd13; exc_code = 5'd10;
    push(KReq, 32'h0, "exl_mask"); push(KRd, 32'h400, "int_cause"); push(KEpc, 32'h3010, "int_epc");
    tick();
    addr = 5'd12; exc_code = 5'd0; hwint = '0; eret = 1'b1;
    push(KRd, 32'h403, "int_sr_exl"); push(KEpc, 32'h3010, "eret_epc");
    tick();
    eret = 1'b0;
    push(KRd, 32'h401, "eret_sr"); push(KEpc, 32'h3010, "eret_epc_hold"); push(KReq, 32'h0, "post_eret_req");

    // Overflow in a delay slot with IE=0
    tick();
    en = 1'b1; wdata = 32'h0000_0400;
    tick();
    en = 1'b0; exc_code = 5'd12; vpc = 32'h3024; bd = 1'b1; hwint = 6'b000001;
    push(KReq, 32'h1, "ov_req");
    tick();
    exc_code = 5'd0; bd = 1'b0; hwint = '0; addr = 5'd13; eret = 1'b1;
    push(KRd, 32'h8000_0430, "ov_cause"); push(KEpc, 32'h3020, "ov_epc");

    // Exception beats a same-cycle mtc0 EPC write
    tick();
    eret = 1'b0; en = 1'b1; addr = 5'd14; wdata = 32'h5000; exc_code = 5'd8; vpc = 32'h3100;
    push(KReq, 32'h1, "sys_req");
    tick();
    en = 1'b0; exc_code = 5'd0; addr = 5'd13;
    push(KRd, 32'h20, "sys_cause"); push(KEpc, 32'h3100, "sys_epc");

    // Asynchronous reset mid-handler
    tick();
    addr = 5'd12; exc_code = 5'd4;
    push(KRd, 32'h0, "async_sr"); push(KEpc, 32'h0, "async_epc"); push(KReq, 32'h0, "async_req");
    #1 reset = 1'b0;
    @(negedge clk);
    #1 exc_code = 5'd0;
    reset = 1'b1;
    tick();
    addr = 5'd13; exc_code = 5'd5; vpc = 32'h3000;
    push(KRd, 32'h0, "async_cause"); push(KReq, 32'h1, "ades_req");
    tick();
    exc_code = 5'd0;
    push(KRd, 32'h14, "ades_cause"); push(KEpc, 32'h3000, "ades_epc");

    // EPC wrap with vpc=0 in a delay slot
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0; exc_code = 5'd4; vpc = 32'h0; bd = 1'b1;
    push(KReq, 32'h1, "wrap_req");
    tick();
    exc_code = 5'd0; bd = 1'b0; addr = 5'd14; eret = 1'b1;
    push(KRd, 32'hFFFF_FFFC, "wrap_epc");

    // req and eret together: eret ignored
    tick();
    exc_code = 5'd10; vpc = 32'h3200;
    push(KReq, 32'h1, "ri_eret_req");
    tick();
    eret = 1'b0; exc_code = 5'd0; addr = 5'd12;
    push(KRd, 32'h2, "ri_eret_sr");

    // mtc0 to Cause ignored, EPC write aligned
    tick();
    en = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    push(KRd, 32'h28, "ri_cause");
    tick();
    addr = 5'd14; wdata = 32'h3007;
    push(KRd, 32'h3200, "ri_epc");
    tick();
    en = 1'b0; addr = 5'd13;
    push(KRd, 32'h28, "cause_ro"); push(KEpc, 32'h3004, "epc_align");

    // EPC write with eret in the same cycle
    tick();
    en = 1'b1; addr = 5'd14; wdata = 32'h4000; eret = 1'b1;
    tick();
    en = 1'b0; eret = 1'b0; addr = 5'd12;
    push(KEpc, 32'h4000, "eret_wr_epc"); push(KRd, 32'h0, "eret_wr_sr");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have one clock and a reset that is asynchronous and active-low, with the ports named as the codebase names them:
- clk      in   1   rising-edge clock
- reset    in   1   asynchronous, active-low
REQ-002 SHALL expose the following ports:
- en        in   1   mtc0 write strobe from the M stage
- addr      in   5   CP0 register number for mtc0/mfc0
- wdata     in   32  mtc0 data
- vpc       in   32  PC of the M-stage instruction (the victim)
- bd        in   1   victim is in a branch delay slot
- exc_code  in   5   exception code of the M-stage instruction; 0 = none
- hwint     in   6   external interrupt lines, level-sensitive
- eret      in   1   M-stage instruction is eret
- req       out  1   exception/interrupt taken; drives PC redirect to 0x4180 and pipeline flush
- rdata     out  32  mfc0 read data
- epc_out   out  32  current EPC, used as the eret target

Function
REQ-003 SHALL hold three registers:
- SR (12): IM[15:10], EXL[1], IE[0]
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]
- EPC (14)
REQ-004 All other SR/Cause bits SHALL read 0 and ignore writes.
REQ-005 int_req SHALL be IE & ~EXL & |(hwint & IM).
REQ-006 exc_req SHALL be (exc_code != 0) & ~EXL.
REQ-007 req SHALL be int_req | exc_req, combinational within the cycle.
REQ-008 req SHALL be forced to 0 while reset is asserted.
REQ-009 Interrupt SHALL take priority over exception; an interrupt records ExcCode = 0.
REQ-010 On a clock edge with req=1, the block SHALL:
- set EXL to 1
- set BD to bd
- set ExcCode to 0 or exc_code, per REQ-009
- set EPC to (bd ? vpc-4 : vpc) with bits[1:0] forced to 0
REQ-011 Cause.IP SHALL sample hwint on every clock edge, independent of req, EXL and IE.
REQ-012 eret=1 with req=0 SHALL clear EXL on that edge; SR and Cause fields other than EXL SHALL be unchanged.
REQ-013 When req and eret are both 1, req SHALL win and eret SHALL be ignored.
REQ-014 When en=1 and req=0:
- addr 12 writes IM, EXL and IE
- addr 14 writes EPC, with bits[1:0] forced to 0
- addr 13 writes nothing (Cause is read-only)
- any other addr is a no-op
REQ-015 When req and en are both 1, req SHALL win and the mtc0 write SHALL be dropped.
REQ-016 rdata SHALL be a combinational read of addr (12/13/14 return the register, others return 0) and SHALL show the pre-edge value.
REQ-017 epc_out SHALL equal EPC combinationally.
REQ-018 A write to EPC in the same cycle as eret SHALL be visible on epc_out the next cycle; bypass is the pipeline's job, not this block's.
REQ-019 While EXL=1, req SHALL stay 0 regardless of hwint or exc_code, so nested exceptions are not taken.
REQ-020 EPC arithmetic SHALL be 32-bit modulo, so vpc=0 with bd=1 yields 0xFFFFFFFC.

Reset
REQ-021 Asserting reset SHALL immediately clear SR, Cause and EPC, without waiting for clk.
REQ-022 While in reset, req SHALL be 0, epc_out SHALL be 0, and rdata for addr 12/13/14 SHALL be 0.
REQ-023 Reset asserted mid-handler (EXL=1) SHALL clear EXL.
REQ-024 After reset releases, the first req SHALL be possible on the first subsequent edge.

Structure
REQ-025 A shared package cp0_pkg SHALL hold:
- register numbers (12/13/14)
- field bit positions
- ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12
- HANDLER_ADDR = 0x4180 and RESET_PC = 0x3000
REQ-026 Request generation and priority SHALL live in the combinational sub-module cp0_req_gen.
REQ-027 The register file and update logic SHALL live in cp0_unit.

Verification
REQ-028 Write SR=0x0000_0401 (IM[10]=1, IE=1), then hwint=6'b000001, vpc=0x3010, bd=0 -> req=1 that cycle; next cycle EPC=0x3010, ExcCode=0, EXL=1, req=0.
REQ-029 exc_code=12 (Ov), vpc=0x3024, bd=1 with IE=0 -> req=1; next cycle EPC=0x3020, BD=1, Cause[6:2]=12.
REQ-030 EXL=1, then exc_code=10 and hwint asserted -> req stays 0; eret -> EXL=0 next cycle, epc_out unchanged.
REQ-031 In one cycle, en=1, addr=14, wdata=0x5000 together with exc_code=8, vpc=0x3100 -> EPC=0x3100 (write dropped), ExcCode=8.
REQ-032 Reset pulsed low between clock edges while EXL=1 and EPC=0x3100 -> SR, Cause and EPC read 0 before the next edge; req=0.
REQ-033 mtc0 addr 13 with wdata=0xFFFF_FFFF -> Cause unchanged; addr 14 with wdata=0x3007 -> EPC=0x3004.
